// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU between two requesters.
// Define DIV_ZERO_GUARD_EN to answer divide-by-zero locally with 8'hFF and rsp_err=1.
module alu_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] a0,
   input  logic [3:0] b0,
   input  logic [3:0] a1,
   input  logic [3:0] b1,
   input  logic [2:0] op0,
   input  logic [2:0] op1,
   output logic       gnt0,
   output logic       gnt1,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_result,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   input  logic       rsp_ready
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e     state_q, state_d;
   logic       gnt0_q, gnt0_d;
   logic       gnt1_q, gnt1_d;
   // 0: req0 wins the next tie, 1: req1 wins the next tie
   logic       prio_q, prio_d;
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic [2:0] alu_op_q, alu_op_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   logic       win_id;
   logic [3:0] win_a;
   logic [3:0] win_b;
   logic [2:0] win_op;
   logic       div_zero;

   always_comb begin
      win_id = (req0 && req1) ? prio_q : req1;
      win_a  = win_id ? a1 : a0;
      win_b  = win_id ? b1 : b0;
      win_op = win_id ? op1 : op0;
   end

`ifdef DIV_ZERO_GUARD_EN
   logic rsp_err_q, rsp_err_d;
   assign div_zero = (win_op == 3'b011) && (win_b == 4'd0);
   assign rsp_err  = rsp_err_q;
`else
   assign div_zero = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      prio_d      = prio_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
`ifdef DIV_ZERO_GUARD_EN
      rsp_err_d   = rsp_err_q;
`endif
      case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               rsp_id_d = win_id;
               prio_d   = ~win_id;
               gnt0_d   = ~win_id;
               gnt1_d   = win_id;
               if (div_zero) begin
                  // Answered locally; the ALU never sees this operation.
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 8'hFF;
`ifdef DIV_ZERO_GUARD_EN
                  rsp_err_d   = 1'b1;
`endif
               end else begin
                  alu_a_d  = {4'b0000, win_a};
                  alu_b_d  = {4'b0000, win_b};
                  alu_op_d = win_op;
                  state_d  = StIssue;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            rsp_data_d  = alu_result;
            rsp_valid_d = 1'b1;
`ifdef DIV_ZERO_GUARD_EN
            rsp_err_d   = 1'b0;
`endif
            state_d     = StResp;
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         prio_q      <= 1'b0;
         alu_a_q     <= 8'd0;
         alu_b_q     <= 8'd0;
         alu_op_q    <= 3'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         prio_q      <= prio_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

`ifdef DIV_ZERO_GUARD_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_err_q <= 1'b0;
      end else begin
         rsp_err_q <= rsp_err_d;
      end
   end
`endif

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

   a_gnt_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));

   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data) && $stable(rsp_id)
                                     && $stable(rsp_err)));

   a_alu_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StWait) |-> ($stable(alu_a) && $stable(alu_b) && $stable(alu_op)));

   a_gnt_once: assert property (@(posedge clk) disable iff (!rst_n)
      (gnt0 || gnt1) |=> !(gnt0 || gnt1));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand-written corner sequences,
// with a response scoreboard. Works with or without DIV_ZERO_GUARD_EN.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1;
   logic [3:0] a0, b0, a1, b1;
   logic [2:0] op0, op1;
   logic       gnt0, gnt1;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       rsp_valid, rsp_id, rsp_err, rsp_ready;
   logic [7:0] rsp_data;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .a0         (a0),
      .b0         (b0),
      .a1         (a1),
      .b1         (b1),
      .op0        (op0),
      .op1        (op1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .rsp_ready  (rsp_ready)
   );

   // Shared ALU with one register stage; divide-by-zero returns a marker value.
   function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b010:  return a & b;
         3'b100:  return a | b;
         3'b101:  return a * b;
         3'b011:  return (b == 8'd0) ? 8'hEE : a / b;
         default: return 8'h00;
      endcase
   endfunction

   always_ff @(posedge clk) alu_result <= alu_model(alu_a, alu_b, alu_op);

   typedef struct {
      logic       id;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic [7:0] data;
      logic       err;
      int         lat;
   } vec_t;

   typedef struct {
      logic       id;
      logic [7:0] data;
      logic       err;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   n_rsp  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Handshake is judged on the values that will be present at the coming rising edge.
   task automatic tick();
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
         n_rsp++;
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id=%0d data=%0h, required no response",
                     rsp_id, rsp_data);
         end else begin
            e = sb.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
      @(negedge clk);
      chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
   endtask

   task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
      if (id) begin
         req1 = 1'b1; a1 = a; b1 = b; op1 = op;
      end else begin
         req0 = 1'b1; a0 = a; b0 = b; op0 = op;
      end
   endtask

   task automatic single_op(input vec_t v);
      bit done = 1'b0;
      bit seen_valid = 1'b0;
      int gnt_own = 0;
      int gnt_other = 0;
      set_req(v.id, v.a, v.b, v.op);
      sb.push_back('{id: v.id, data: v.data, err: v.err});
      for (int c = 1; c <= 20 && !done; c++) begin
         tick();
         if (v.id ? gnt1 : gnt0) begin
            gnt_own++;
            if (v.id) req1 = 1'b0;
            else req0 = 1'b0;
            if (v.lat == 3) begin
               chk("issue_alu_a", 32'(alu_a), 32'({4'h0, v.a}));
               chk("issue_alu_b", 32'(alu_b), 32'({4'h0, v.b}));
               chk("issue_alu_op", 32'(alu_op), 32'(v.op));
            end
         end
         if (v.id ? gnt0 : gnt1) gnt_other++;
         if (rsp_valid && !seen_valid) begin
            seen_valid = 1'b1;
            chk("latency", 32'(c), 32'(v.lat));
         end
         if (rsp_valid && rsp_ready) done = 1'b1;
      end
      chk("op_done", 32'(done), 32'd1);
      chk("gnt_pulses", 32'(gnt_own), 32'd1);
      chk("gnt_other", 32'(gnt_other), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   gcount;
      logic order [2];
      bit   done;
      int   rsp_base;

      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; op0 = '0; op1 = '0;
      rsp_ready = 1'b1;

      vecs[0] = '{1'b0, 4'd3,  4'd5,  3'b000, 8'h08, 1'b0, 3};
      vecs[1] = '{1'b1, 4'd9,  4'd2,  3'b001, 8'h07, 1'b0, 3};
      vecs[2] = '{1'b0, 4'd15, 4'd15, 3'b101, 8'hE1, 1'b0, 3};
      vecs[3] = '{1'b1, 4'd12, 4'd10, 3'b010, 8'h08, 1'b0, 3};
      vecs[4] = '{1'b0, 4'd12, 4'd3,  3'b100, 8'h0F, 1'b0, 3};
      vecs[5] = '{1'b1, 4'd15, 4'd4,  3'b011, 8'h03, 1'b0, 3};
      vecs[6] = '{1'b0, 4'd6,  4'd7,  3'b110, 8'h00, 1'b0, 3};
      vecs[7] = '{1'b1, 4'd2,  4'd5,  3'b001, 8'hFD, 1'b0, 3};
`ifdef DIV_ZERO_GUARD_EN
      vecs[8] = '{1'b0, 4'd4,  4'd0,  3'b011, 8'hFF, 1'b1, 1};
`else
      vecs[8] = '{1'b0, 4'd4,  4'd0,  3'b011, 8'hEE, 1'b0, 3};
`endif

      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
      rst_n = 1'b1;

      // Tie held over two operations: req0 first after reset, then req1.
      set_req(1'b0, 4'd9, 4'd2, 3'b001);
      set_req(1'b1, 4'd7, 4'd6, 3'b101);
      sb.push_back('{id: 1'b0, data: 8'h07, err: 1'b0});
      sb.push_back('{id: 1'b1, data: 8'h2A, err: 1'b0});
      gcount = 0;
      order[0] = 1'b1;
      order[1] = 1'b0;
      rsp_base = n_rsp;
      for (int c = 0; c < 30 && (n_rsp - rsp_base) < 2; c++) begin
         tick();
         if (gnt0 || gnt1) begin
            if (gcount < 2) order[gcount] = gnt1;
            gcount++;
            if (gcount == 2) begin
               req0 = 1'b0;
               req1 = 1'b0;
            end
         end
      end
      chk("tie_gnt_count", 32'(gcount), 32'd2);
      chk("tie_first_winner", 32'(order[0]), 32'd0);
      chk("tie_second_winner", 32'(order[1]), 32'd1);
      chk("tie_responses", 32'(n_rsp - rsp_base), 32'd2);

      for (int i = 0; i < 9; i++) single_op(vecs[i]);

`ifdef DIV_ZERO_GUARD_EN
      chk("div0_alu_untouched", 32'({alu_a, alu_b, alu_op}), 32'({8'h02, 8'h05, 3'b001}));
`endif

      // Backpressure: response held while rsp_ready is low, req1 waits for the next IDLE.
      rsp_ready = 1'b0;
      set_req(1'b0, 4'd5, 4'd6, 3'b000);
      sb.push_back('{id: 1'b0, data: 8'h0B, err: 1'b0});
      done = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         tick();
         if (gnt0) req0 = 1'b0;
         if (rsp_valid) done = 1'b1;
      end
      chk("bp_reached_resp", 32'(done), 32'd1);
      set_req(1'b1, 4'd1, 4'd1, 3'b000);
      sb.push_back('{id: 1'b1, data: 8'h02, err: 1'b0});
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
         chk("bp_data_hold", 32'(rsp_data), 32'h0B);
         chk("bp_id_hold", 32'(rsp_id), 32'd0);
         chk("bp_no_gnt", 32'({gnt0, gnt1}), 32'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_no_gnt_in_idle", 32'({gnt0, gnt1}), 32'd0);
      tick();
      chk("bp_gnt1_after", 32'({gnt0, gnt1}), 32'b01);
      req1 = 1'b0;
      tick();
      tick();
      chk("bp2_valid", 32'(rsp_valid), 32'd1);
      tick();

      // Reset during WAIT: operation abandoned, outputs cleared at once.
      set_req(1'b0, 4'd1, 4'd2, 3'b000);
      tick();
      chk("mid_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      tick();
      chk("mid_in_wait", 32'({gnt0, gnt1, rsp_valid}), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_async", {gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_data, alu_a, alu_b,
                            alu_op}, 32'd0);
      set_req(1'b1, 4'd3, 4'd3, 3'b101);
      tick();
      chk("mid_rst_held", {gnt0, gnt1, rsp_valid, rsp_id, rsp_err, rsp_data, alu_a, alu_b,
                           alu_op}, 32'd0);
      sb.push_back('{id: 1'b1, data: 8'h09, err: 1'b0});
      rst_n = 1'b1;
      tick();
      chk("mid_first_arb_gnt1", 32'({gnt0, gnt1}), 32'b01);
      req1 = 1'b0;
      tick();
      chk("mid_no_early_valid", 32'(rsp_valid), 32'd0);
      tick();
      chk("mid_rsp_valid", 32'(rsp_valid), 32'd1);
      tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("rsp_total", 32'(n_rsp), 32'd14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
